// File: rtl/ram_write_sequencer.sv
// Writes a valid/ready pixel stream to consecutive RAM addresses from a programmed base.
// Optional macro STRIDE_EN adds a per-transfer address stride input (default build: stride fixed at 1).
module ram_write_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
`ifdef STRIDE_EN
    input  logic [STEP_W-1:0] stride,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  rem;
    logic [STEP_W-1:0] step;
    logic              start_ok;
    logic              accept;

    assign start_ok = (state == IDLE) && start;
    assign accept   = (state == RUN) && in_valid;

    // Handshake and status outputs decode directly from the registered state.
    assign in_ready = (state == RUN);
    assign busy     = (state == RUN) || (state == LAST);
    assign done     = (state == LAST);

    // NOTE: async reset appears in the sensitivity list; sequential state uses <= only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next state gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? LAST : RUN;
                end
            end
            RUN: begin
                if (accept && (rem == LEN_W'(1))) begin
                    state_next = LAST;
                end
            end
            LAST:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef STRIDE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= '0;
        end else if (start_ok) begin
            step <= stride;
        end
    end
`else
    assign step = STEP_W'(1);
`endif

    // A beat accepted in cycle t drives the RAM port in cycle t+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr  <= '0;
            rem   <= '0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= accept;
            if (start_ok) begin
                addr <= base_addr;
                rem  <= length;
            end else if (accept) begin
                waddr <= addr;
                wdata <= in_data;
                addr  <= addr + ADDR_W'(step);
                rem   <= rem - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ram_write_sequencer.sv
// Directed self-checking bench for ram_write_sequencer; stride case runs only with STRIDE_EN.
`timescale 1ns/1ps
module tb_ram_write_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
`ifdef STRIDE_EN
    logic [2:0]  stride;
`endif
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    ram_write_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
`ifdef STRIDE_EN
        .stride    (stride),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Backpressure pattern: 1,0,0,1,0,1 (bit 0 first)
    logic [5:0] bp_pat = 6'b101001;
    logic [15:0] wrap_addr [3];

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        in_valid = 1'b0; in_data = '0;
`ifdef STRIDE_EN
        stride = 3'd1;
`endif
        wrap_addr[0] = 16'hFFFE; wrap_addr[1] = 16'hFFFF; wrap_addr[2] = 16'h0000;
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_we",       we,       0);
        check("rst_busy",     busy,     0);
        check("rst_done",     done,     0);
        check("rst_waddr",    waddr,    0);
        check("rst_wdata",    wdata,    0);
        rst = 1'b0;
        tick();

        // in_valid in IDLE is not accepted
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        check("idle_no_we",    we,       0);
        check("idle_no_ready", in_ready, 0);
        in_valid = 1'b0;

        // Basic: base 0x0100, length 4, data A0..A3
        do_start(16'h0100, 16'd4);
        check("basic_busy",  busy,     1);
        check("basic_ready", in_ready, 1);
        check("basic_we0",   we,       0);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 8'hA0 + 8'(k);
            tick();
            check("basic_we",    we,    1);
            check("basic_waddr", waddr, 16'h0100 + 16'(k));
            check("basic_wdata", wdata, 8'hA0 + 8'(k));
            check("basic_done",  done,  (k == 3) ? 1 : 0);
        end
        check("basic_last_ready", in_ready, 0);
        in_valid = 1'b0;
        tick();
        check("basic_idle_we",   we,   0);
        check("basic_idle_done", done, 0);
        check("basic_idle_busy", busy, 0);

        // Backpressure gaps: length 3, pattern 1,0,0,1,0,1
        do_start(16'h0200, 16'd3);
        begin
            int nw = 0;
            for (int i = 0; i < 6; i++) begin
                in_valid = bp_pat[i];
                in_data  = 8'hB0 + 8'(i);
                tick();
                check("bp_we",   we,   bp_pat[i]);
                check("bp_busy", busy, 1);
                check("bp_done", done, (i == 5) ? 1 : 0);
                if (bp_pat[i]) begin
                    check("bp_waddr", waddr, 16'h0200 + 16'(nw));
                    check("bp_wdata", wdata, 8'hB0 + 8'(i));
                    nw++;
                end
            end
            check("bp_nwrites", nw, 3);
        end
        in_valid = 1'b0;
        tick();
        check("bp_idle_busy", busy, 0);

        // Zero length: no write, done and busy in the cycle after start
        do_start(16'h0300, 16'd0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 1);
        check("zero_we",   we,   0);
        // start coincident with done is ignored
        start = 1'b1; length = 16'd5;
        tick();
        start = 1'b0;
        check("zero_idle_done",   done, 0);
        check("start_in_last_ign", busy, 0);
        check("zero_idle_we",     we,   0);

        // Wrap: base 0xFFFE, length 3; a start during RUN must not disturb it
        do_start(16'hFFFE, 16'd3);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'hC0 + 8'(k);
            start = (k == 1); base_addr = 16'h1234; length = 16'd9;
            tick();
            check("wrap_we",    we,    1);
            check("wrap_waddr", waddr, wrap_addr[k]);
            check("wrap_done",  done,  (k == 2) ? 1 : 0);
        end
        start = 1'b0; in_valid = 1'b0;
        tick();
        check("wrap_idle_busy", busy, 0);

        // Reset mid-run after 2 of 5 accepts
        do_start(16'h0400, 16'd5);
        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_data = 8'hD0 + 8'(k);
            tick();
        end
        check("mid_we_before", we, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_we",    we,       0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_busy",  busy,     0);
        check("mid_rst_done",  done,     0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_done", done, 0);
            check("post_rst_we",   we,   0);
        end
        in_valid = 1'b0;
        do_start(16'h0010, 16'd1);
        in_valid = 1'b1; in_data = 8'hE7;
        tick();
        check("single_we",    we,    1);
        check("single_waddr", waddr, 16'h0010);
        check("single_wdata", wdata, 8'hE7);
        check("single_done",  done,  1);
        tick();
        check("single_after_we", we, 0);
        in_valid = 1'b0;

`ifdef STRIDE_EN
        // Stride 4 from base 0: 0x0000, 0x0004, 0x0008
        stride = 3'd4;
        do_start(16'h0000, 16'd3);
        stride = 3'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'hF0 + 8'(k);
            start = (k == 0); base_addr = 16'h0100;
            tick();
            check("stride_we",    we,    1);
            check("stride_waddr", waddr, 16'(4 * k));
        end
        start = 1'b0; in_valid = 1'b0;
        tick();
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
